// File: rtl/cmult_pipe_if.sv
// Handshake and data bundle for the pipelined complex multiplier.
// The master side drives samples in; the slave side is the multiplier.
interface cmult_pipe_if #(
    parameter int DW = 16,
    parameter int TW = 8,
    parameter int CW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [TW-1:0] w_re;
    logic signed [TW-1:0] w_im;
    logic                 rnd_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] p_re;
    logic signed [DW-1:0] p_im;
    logic                 sat;
    logic [CW-1:0]        sat_cnt;
    logic                 cnt_clr;

    modport master (
        output in_valid, a_re, a_im, w_re, w_im, rnd_mode, out_ready, cnt_clr,
        input  in_ready, out_valid, p_re, p_im, sat, sat_cnt
    );

    modport slave (
        input  in_valid, a_re, a_im, w_re, w_im, rnd_mode, out_ready, cnt_clr,
        output in_ready, out_valid, p_re, p_im, sat, sat_cnt
    );
endinterface

// File: rtl/cmult_pipe.sv
// Three-stage pipelined complex multiplier P = A*W with Q1.(TW-1) twiddles,
// per-sample truncate/round, output saturation and a saturation event counter.
module cmult_pipe #(
    parameter int DW = 16,
    parameter int TW = 8,
    parameter int CW = 16
) (
    input logic       clk,
    input logic       rst,
    cmult_pipe_if.slave bus
);
    localparam int PW = DW + TW;
    localparam int FW = DW + TW + 1;

    localparam logic signed [FW-1:0] SAT_MAX = {{(TW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [FW-1:0] SAT_MIN = {{(TW+2){1'b1}}, {(DW-1){1'b0}}};

    logic stall;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_a_re;
    logic signed [DW-1:0] s1_a_im;
    logic signed [TW-1:0] s1_w_re;
    logic signed [TW-1:0] s1_w_im;
    logic                 s1_rnd;

    logic                 s2_valid;
    logic signed [PW-1:0] s2_rr;
    logic signed [PW-1:0] s2_ii;
    logic signed [PW-1:0] s2_ri;
    logic signed [PW-1:0] s2_ir;
    logic                 s2_rnd;

    logic signed [FW-1:0] re_full;
    logic signed [FW-1:0] im_full;
    logic signed [FW-1:0] rnd_add;
    logic signed [FW-1:0] re_rnd;
    logic signed [FW-1:0] im_rnd;
    logic signed [FW-1:0] re_sh;
    logic signed [FW-1:0] im_sh;
    logic [DW:0]          re_clip;
    logic [DW:0]          im_clip;

    logic                 out_valid_q;
    logic signed [DW-1:0] p_re_q;
    logic signed [DW-1:0] p_im_q;
    logic                 sat_q;
    logic [CW-1:0]        sat_cnt_q;

    // A result that cannot leave freezes every stage, valid bits included.
    assign stall = out_valid_q & ~bus.out_ready;

    function automatic logic [DW:0] clip(input logic signed [FW-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[DW-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[DW-1:0]};
        end else begin
            return {1'b0, v[DW-1:0]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_w_re  <= '0;
            s1_w_im  <= '0;
            s1_rnd   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a_re <= bus.a_re;
                s1_a_im <= bus.a_im;
                s1_w_re <= bus.w_re;
                s1_w_im <= bus.w_im;
                s1_rnd  <= bus.rnd_mode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
            s2_rnd   <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_rr  <= PW'(s1_a_re) * PW'(s1_w_re);
                s2_ii  <= PW'(s1_a_im) * PW'(s1_w_im);
                s2_ri  <= PW'(s1_a_re) * PW'(s1_w_im);
                s2_ir  <= PW'(s1_a_im) * PW'(s1_w_re);
                s2_rnd <= s1_rnd;
            end
        end
    end

    // Rounding adds half an LSB of the scaled result before the floor shift.
    always_comb begin
        rnd_add         = '0;
        rnd_add[TW-2]   = s2_rnd;
        re_full         = FW'(s2_rr) - FW'(s2_ii);
        im_full         = FW'(s2_ri) + FW'(s2_ir);
        re_rnd          = re_full + rnd_add;
        im_rnd          = im_full + rnd_add;
        re_sh           = re_rnd >>> (TW - 1);
        im_sh           = im_rnd >>> (TW - 1);
        re_clip         = clip(re_sh);
        im_clip         = clip(im_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            sat_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                p_re_q <= re_clip[DW-1:0];
                p_im_q <= im_clip[DW-1:0];
                sat_q  <= re_clip[DW] | im_clip[DW];
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            sat_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && sat_q && (sat_cnt_q != {CW{1'b1}})) begin
            sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.p_re      = p_re_q;
    assign bus.p_im      = p_im_q;
    assign bus.sat       = sat_q;
    assign bus.sat_cnt   = sat_cnt_q;

endmodule
